// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch queue signal bundle: redirect, imem request/response, decode handshake
interface fetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with redirect squash
// Optional same-cycle response-to-decode bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [PW-1:0] q_head, q_tail, af_head, af_tail;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   af_addr [DEPTH];

  logic [CW:0] reserved;
  logic        req_fire, rsp_ok, rsp_keep, q_valid, q_push, q_pop, byp_hit;

  // A request is only issued when a queue slot is guaranteed for its response.
  assign reserved           = {1'b0, occupancy} + {1'b0, outstanding};
  assign bus.imem_req_valid = rst_n & ~bus.redirect_valid & (reserved < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc;

  assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_ok   = bus.imem_rsp_valid & (outstanding != '0);
  assign rsp_keep = rsp_ok & (drop_cnt == '0);
  assign q_valid  = (occupancy != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp_hit = rsp_keep & ~q_valid;
`else
  assign byp_hit = 1'b0;
`endif

  assign bus.dec_valid = q_valid | byp_hit;
  assign q_pop         = q_valid & bus.dec_ready;
  assign q_push        = rsp_keep & ~bus.redirect_valid & ~(byp_hit & bus.dec_ready);

  always_comb begin
    bus.dec_instr = '0;
    bus.dec_pc    = '0;
    if (q_valid) begin
      bus.dec_instr = q_instr[q_head];
      bus.dec_pc    = q_pc[q_head];
    end else if (byp_hit) begin
      bus.dec_instr = bus.imem_rsp_data;
      bus.dec_pc    = af_addr[af_head];
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) af_addr[af_tail] <= fetch_pc;
    if (q_push) begin
      q_instr[q_tail] <= bus.imem_rsp_data;
      q_pc[q_tail]    <= af_addr[af_head];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      occupancy   <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      af_head     <= '0;
      af_tail     <= '0;
    end else begin
      if (req_fire) af_tail <= af_tail + PW'(1);
      if (rsp_ok)   af_head <= af_head + PW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
      // Every request still in flight after a redirect belongs to the old path.
      if (bus.redirect_valid) begin
        fetch_pc  <= bus.redirect_pc;
        drop_cnt  <= outstanding - CW'(rsp_ok);
        occupancy <= '0;
        q_head    <= q_tail;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd1;
        if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (q_push) q_tail <= q_tail + PW'(1);
        if (q_pop)  q_head <= q_head + PW'(1);
        occupancy <= occupancy + CW'(q_push) - CW'(q_pop);
      end
    end
  end

`ifndef SYNTHESIS
  rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.imem_rsp_valid && (outstanding == '0)));
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue, valid with or without FETCH_QUEUE_BYPASS_EN
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { bit drdy; bit req_v; logic [31:0] req_addr; bit dec_v; logic [31:0] dec_pc; } vec_t;

  mreq_t       mem_q[$];   // requests accepted by memory, in order
  logic [31:0] mq[$];      // pcs the decode side should see, in order
  logic [31:0] m_pc;
  int          m_drop;
  int          cyc;
  int          n_cmp, n_err;

  logic        s_req_v, s_dec_v, s_rsp_v;
  logic [31:0] s_req_addr, s_dec_pc, s_dec_instr, s_rsp_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: called at a falling edge, drives inputs, checks, updates model, waits for next falling edge.
  task automatic step(input bit drdy, input bit redir, input logic [31:0] rpc,
                      input bit mrdy, input bit rsp_en, input int lat);
    bit          rv, byp_take, exp_dv, exp_rq;
    logic [31:0] raddr, exp_pc;
    rv    = rsp_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    raddr = rv ? mem_q[0].addr : 32'h0;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = mrdy;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rv ? instr_of(raddr) : 32'hDEAD_BEEF;
    bus.dec_ready      = drdy;
    #1;
    s_req_v = bus.imem_req_valid; s_req_addr = bus.imem_req_addr;
    s_dec_v = bus.dec_valid; s_dec_pc = bus.dec_pc; s_dec_instr = bus.dec_instr;
    s_rsp_v = rv; s_rsp_addr = raddr;

    byp_take = BYP && rv && (m_drop == 0) && (mq.size() == 0);
    exp_dv   = (mq.size() != 0) || byp_take;
    exp_pc   = (mq.size() != 0) ? mq[0] : raddr;
    check("dec_valid", 32'(s_dec_v), 32'(exp_dv));
    if (exp_dv) begin
      check("dec_pc", s_dec_pc, exp_pc);
      check("dec_instr", s_dec_instr, instr_of(exp_pc));
    end
    exp_rq = !redir && (mq.size() + mem_q.size() < DEPTH);
    check("req_valid", 32'(s_req_v), 32'(exp_rq));
    if (exp_rq) check("req_addr", s_req_addr, m_pc);

    if (redir) begin
      mq.delete();
      m_drop = mem_q.size() - (rv ? 1 : 0);
      m_pc   = rpc;
    end else begin
      if (drdy && mq.size() != 0) void'(mq.pop_front());
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else if (!(byp_take && drdy)) mq.push_back(raddr);
      end
      if (exp_rq && mrdy) m_pc = m_pc + 32'd1;
    end
    if (rv) void'(mem_q.pop_front());
    if (s_req_v && mrdy) mem_q.push_back('{s_req_addr, cyc + lat});
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0; bus.dec_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst dec_valid", 32'(bus.dec_valid), 32'd0);
    check("rst dec_instr", bus.dec_instr, 32'd0);
    check("rst dec_pc", bus.dec_pc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); mem_q.delete();
    m_pc = RESET_PC; m_drop = 0;
  endtask

  // Runs a steady stream until both the first request and the first decode entry are seen.
  task automatic expect_first(input string nm, input logic [31:0] pc);
    bit got_req, got_dec;
    got_req = 0; got_dec = 0;
    for (int i = 0; i < 30 && !(got_req && got_dec); i++) begin
      step(1, 0, 0, 1, 1, 1);
      if (!got_req && s_req_v) begin got_req = 1; check({nm, " first req"}, s_req_addr, pc); end
      if (!got_dec && s_dec_v) begin got_dec = 1; check({nm, " first dec_pc"}, s_dec_pc, pc); end
    end
    check({nm, " seen"}, 32'({got_req, got_dec}), 32'd3);
  endtask

  vec_t tbl[11];

  initial begin
    logic [31:0] reqs[2], decs[2];
    int nr, nd, pops;
    bit found;

    tbl[0]  = '{0, 1, 32'd0, 0,   32'd0};
    tbl[1]  = '{0, 1, 32'd1, BYP, 32'd0};
    tbl[2]  = '{0, 1, 32'd2, 1,   32'd0};
    tbl[3]  = '{0, 1, 32'd3, 1,   32'd0};
    tbl[4]  = '{0, 0, 32'd0, 1,   32'd0};
    tbl[5]  = '{0, 0, 32'd0, 1,   32'd0};
    tbl[6]  = '{1, 0, 32'd0, 1,   32'd0};
    tbl[7]  = '{1, 1, 32'd4, 1,   32'd1};
    tbl[8]  = '{1, 1, 32'd5, 1,   32'd2};
    tbl[9]  = '{1, 1, 32'd6, 1,   32'd3};
    tbl[10] = '{1, 1, 32'd7, 1,   32'd4};

    n_cmp = 0; n_err = 0; cyc = 0;
    rst_n = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0; bus.dec_ready = 1'b0;
    #2;
    do_reset();

    // fill with decode stalled, then drain one per cycle
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].drdy, 0, 0, 1, 1, 1);
      check($sformatf("tbl%0d req_valid", i), 32'(s_req_v), 32'(tbl[i].req_v));
      if (tbl[i].req_v) check($sformatf("tbl%0d req_addr", i), s_req_addr, tbl[i].req_addr);
      check($sformatf("tbl%0d dec_valid", i), 32'(s_dec_v), 32'(tbl[i].dec_v));
      if (tbl[i].dec_v) check($sformatf("tbl%0d dec_pc", i), s_dec_pc, tbl[i].dec_pc);
    end

    // two outstanding requests squashed by a redirect
    do_reset();
    step(1, 1, 32'd5, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    check("squash req5", s_req_addr, 32'd5);
    step(1, 0, 0, 1, 0, 1);
    check("squash req6", s_req_addr, 32'd6);
    step(1, 1, 32'h40, 1, 0, 1);
    check("squash redirect req_valid", 32'(s_req_v), 32'd0);
    expect_first("squash", 32'h40);

    // back-to-back redirects, each coinciding with a response
    do_reset();
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 1, 32'h100, 0, 1, 1);
    step(1, 1, 32'h200, 0, 1, 1);
    expect_first("double redirect", 32'h200);

    // address wrap
    step(1, 1, 32'hFFFF_FFFF, 1, 1, 1);
    nr = 0; nd = 0;
    for (int i = 0; i < 30 && (nr < 2 || nd < 2); i++) begin
      step(1, 0, 0, 1, 1, 1);
      if (nr < 2 && s_req_v) begin reqs[nr] = s_req_addr; nr++; end
      if (nd < 2 && s_dec_v) begin decs[nd] = s_dec_pc; nd++; end
    end
    check("wrap count", 32'(nr + nd), 32'd4);
    check("wrap req0", reqs[0], 32'hFFFF_FFFF);
    check("wrap req1", reqs[1], 32'h0);
    check("wrap dec0", decs[0], 32'hFFFF_FFFF);
    check("wrap dec1", decs[1], 32'h0);

    // bypass latency from an empty queue
    do_reset();
    step(1, 1, 32'd7, 1, 1, 1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1, 0, 0, 1, 1, 1);
      if (s_rsp_v && s_rsp_addr == 32'd7) begin
        found = 1;
        check("rsp7 dec_valid", 32'(s_dec_v), 32'(BYP));
        if (BYP) check("rsp7 bypass dec_pc", s_dec_pc, 32'd7);
        step(1, 0, 0, 1, 1, 1);
        check("after rsp7 dec_valid", 32'(s_dec_v), 32'd1);
        check("after rsp7 dec_pc", s_dec_pc, BYP ? 32'd8 : 32'd7);
      end
    end
    check("rsp7 seen", 32'(found), 32'd1);

    // reset mid-stream with three queued entries
    do_reset();
    for (int i = 0; i < 10 && mq.size() < 3; i++) step(0, 0, 0, 1, 1, 1);
    check("prefill size", 32'(mq.size()), 32'd3);
    do_reset();
    step(1, 0, 0, 1, 1, 1);
    check("post-reset req_valid", 32'(s_req_v), 32'd1);
    check("post-reset req_addr", s_req_addr, RESET_PC);

    // randomized traffic against the reference model
    do_reset();
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      bit drdy, redir;
      logic [31:0] rpc;
      drdy  = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 39) == 0) || ((i % 250) == 101);
      rpc   = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
      step(drdy, redir, rpc, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, $urandom_range(1, 4));
      if (s_dec_v && drdy) pops++;
      if ((i % 250) == 101) step(1, 1, 32'h1000 + 32'(i), 1, 1, 1);
    end
    check("random progress", 32'(pops >= 300), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
